// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with a combinational head read and an occupancy count.
module sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned LW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LW'(depth));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO front end drained back-to-back by a serializer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq = 12_000_000,
  parameter int unsigned baud     = 9_600,
  parameter int unsigned depth    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(depth):0]   level,
  output logic                     tx,
  output logic                     tx_busy
);

  localparam int unsigned CPB = clks_per_bit(clk_freq, baud);
  localparam int unsigned CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CPB - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q;
  logic          pop;
  logic          empty;
  logic [7:0]    rd_data;

  sync_fifo #(
    .width (8),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= wr_en && full;
    end
  end

  // tx_d is the line level for the state being entered, so tx is a clean register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rd_data;
          cnt_d   = CNT_LOAD;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          idx_d   = '0;
          cnt_d   = CNT_LOAD;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - CW'(1);
          tx_d  = 1'b0;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          tx_d  = shift_q[0];
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = rd_data;
            cnt_d   = CNT_LOAD;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          tx_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign tx_busy  = (state_q != IDLE) || (level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: fast instance (8 clocks/bit) plus a default-rate instance.
module tb_uart_tx_fifo;

  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, overflow, tx, tx_busy;
  logic [4:0] level;

  logic       rst2 = 1'b1;
  logic       wr_en2 = 1'b0;
  logic [7:0] wr_data2 = '0;
  logic       full2, overflow2, tx2, busy2;
  logic [4:0] level2;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [7:0]  q_data[$];
  int unsigned q_start[$];
  bit          q_stop_ok[$];

  uart_tx_fifo #(.clk_freq(8), .baud(1), .depth(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .overflow(overflow), .level(level), .tx(tx), .tx_busy(tx_busy)
  );

  uart_tx_fifo dut2 (
    .clk(clk), .rst(rst2), .wr_en(wr_en2), .wr_data(wr_data2), .full(full2),
    .overflow(overflow2), .level(level2), .tx(tx2), .tx_busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic mon_wait(input int unsigned n, inout bit ab);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Line receiver: samples mid-bit and logs each complete frame with its first start cycle.
  initial begin : monitor
    logic        prev;
    logic [7:0]  b;
    int unsigned st;
    bit          ab, sok;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !tx) begin
        st = cyc; ab = 1'b0; sok = 1'b1;
        mon_wait(CPB / 2, ab);
        if (tx !== 1'b0) sok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, ab);
          b[i] = tx;
        end
        mon_wait(CPB, ab);
        if (tx !== 1'b1) sok = 1'b0;
        if (!ab) begin
          q_data.push_back(b);
          q_start.push_back(st);
          q_stop_ok.push_back(sok);
        end
      end
      prev = tx;
    end
  end

  task automatic wait_idle(input int unsigned limit, output int unsigned fc);
    fc = 0;
    for (int unsigned k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!tx_busy) begin
        fc = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (tx2 !== 1'b1) begin n_fail++; $display("FAIL reset_tx2: got %b expected 1", tx2); end
    rst = 1'b0; rst2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [9:0]  pat;
    int unsigned e0, fc;
    bit          bad_tx, bad_busy;
    pat = {1'b1, 8'hA5, 1'b0};
    bad_tx = 1'b0; bad_busy = 1'b0;
    q_data.delete(); q_start.delete(); q_stop_ok.delete();
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0; e0 = cyc;
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", level); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_tx: got %b expected 1", tx); end
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_early: got %b expected 1", tx_busy); end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx !== pat[i / 8]) bad_tx = 1'b1;
      if (tx_busy !== 1'b1) bad_busy = 1'b1;
    end
    n_checks++; if (bad_tx) begin n_fail++; $display("FAIL single_waveform: got mismatching bits expected 0101001011 x8"); end
    n_checks++; if (bad_busy) begin n_fail++; $display("FAIL single_busy_frame: got low expected high for 80 cycles"); end
    @(negedge clk);
    fc = cyc;
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0 at cycle %0d", tx_busy, fc); end
    n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL single_frames: got %0d expected 1", q_data.size()); end
    else begin
      n_checks++; if (q_data[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %0h expected a5", q_data[0]); end
      n_checks++; if (q_start[0] != e0 + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", q_start[0], e0 + 1); end
      n_checks++; if (!q_stop_ok[0]) begin n_fail++; $display("FAIL single_framing: got bad start/stop expected 0/1"); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_d [3];
    int unsigned e0, fc;
    logic [4:0]  peak;
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h55;
    q_data.delete(); q_start.delete(); q_stop_ok.delete();
    peak = '0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = exp_d[i];
      @(negedge clk);
      if (i == 0) e0 = cyc;
      if (level > peak) peak = level;
    end
    wr_en = 1'b0;
    fc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (level > peak) peak = level;
      if (!tx_busy) begin fc = cyc; break; end
    end
    n_checks++; if (peak !== 5'd2) begin n_fail++; $display("FAIL b2b_peak_level: got %0d expected 2", peak); end
    n_checks++; if (fc != e0 + 241) begin n_fail++; $display("FAIL b2b_busy_fall: got %0d expected %0d", fc, e0 + 241); end
    n_checks++; if (q_data.size() != 3) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 3", q_data.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (q_data[i] !== exp_d[i] || !q_stop_ok[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %0h expected %0h", i, q_data[i], exp_d[i]); end
        n_checks++; if (q_start[i] != e0 + 1 + 80 * i) begin n_fail++; $display("FAIL b2b_start%0d: got %0d expected %0d", i, q_start[i], e0 + 1 + 80 * i); end
      end
    end
  endtask

  task automatic test_overflow();
    int unsigned e0, fc, pulses;
    bit          bad;
    q_data.delete(); q_start.delete(); q_stop_ok.delete();
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      @(negedge clk);
      if (i == 0) e0 = cyc;
      if (overflow) pulses++;
      if (i == 15) begin
        n_checks++; if (full !== 1'b0 || level !== 5'd15) begin n_fail++; $display("FAIL ovf_w16: got full=%b level=%0d expected full=0 level=15", full, level); end
      end
      if (i == 16) begin
        n_checks++; if (full !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL ovf_w17: got full=%b level=%0d expected full=1 level=16", full, level); end
      end
      if (i == 17) begin
        n_checks++; if (overflow !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL ovf_w18: got overflow=%b level=%0d expected overflow=1 level=16", overflow, level); end
      end
    end
    wr_en = 1'b0;
    fc = 0;
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk);
      if (overflow) pulses++;
      if (!tx_busy) begin fc = cyc; break; end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 1", pulses); end
    n_checks++; if (fc != e0 + 1 + 17 * 80) begin n_fail++; $display("FAIL ovf_busy_fall: got %0d expected %0d", fc, e0 + 1 + 17 * 80); end
    n_checks++; if (q_data.size() != 17) begin n_fail++; $display("FAIL ovf_frames: got %0d expected 17", q_data.size()); end
    else begin
      bad = 1'b0;
      for (int i = 0; i < 17; i++)
        if (q_data[i] !== 8'(8'h10 + i) || q_start[i] != e0 + 1 + 80 * i || !q_stop_ok[i]) bad = 1'b1;
      n_checks++; if (bad) begin n_fail++; $display("FAIL ovf_sequence: got wrong byte/timing expected 10..20 contiguous"); end
    end
  endtask

  task automatic test_simul_pop_write();
    int unsigned e0, fc;
    q_data.delete(); q_start.delete(); q_stop_ok.delete();
    wr_en = 1'b1; wr_data = 8'hC1;
    @(negedge clk);
    wr_en = 1'b0; e0 = cyc;
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hC2;
    @(negedge clk);
    wr_en = 1'b0;
    while (cyc < e0 + 80) @(negedge clk);
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL simul_level_before: got %0d expected 1", level); end
    wr_en = 1'b1; wr_data = 8'hC3;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL simul_level_after: got %0d expected 1", level); end
    wait_idle(400, fc);
    n_checks++; if (fc != e0 + 241) begin n_fail++; $display("FAIL simul_busy_fall: got %0d expected %0d", fc, e0 + 241); end
    n_checks++; if (q_data.size() != 3) begin n_fail++; $display("FAIL simul_frames: got %0d expected 3", q_data.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (q_data[i] !== 8'(8'hC1 + i) || q_start[i] != e0 + 1 + 80 * i) begin n_fail++; $display("FAIL simul_order%0d: got %0h@%0d expected %0h@%0d", i, q_data[i], q_start[i], 8'(8'hC1 + i), e0 + 1 + 80 * i); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int unsigned e0, fc;
    bit          bad;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
      @(negedge clk);
      if (i == 0) e0 = cyc;
    end
    wr_en = 1'b0;
    while (cyc < e0 + 36) @(negedge clk);
    n_checks++; if (level !== 5'd5 || tx !== 1'b0) begin n_fail++; $display("FAIL rmid_pre: got level=%0d tx=%b expected level=5 tx=0", level, tx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (tx !== 1'b1 || level !== 5'd0 || tx_busy !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got tx=%b level=%0d busy=%b expected 1/0/0", tx, level, tx_busy); end
    q_data.delete(); q_start.delete(); q_stop_ok.delete();
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad || q_data.size() != 0) begin n_fail++; $display("FAIL rmid_quiet: got activity (%0d frames) expected idle line", q_data.size()); end
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0; e0 = cyc;
    wait_idle(200, fc);
    n_checks++; if (fc != e0 + 81) begin n_fail++; $display("FAIL rmid_new_busy: got %0d expected %0d", fc, e0 + 81); end
    n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL rmid_new_frames: got %0d expected 1", q_data.size()); end
    else begin
      n_checks++; if (q_data[0] !== 8'h3C || q_start[0] != e0 + 1) begin n_fail++; $display("FAIL rmid_new_data: got %0h@%0d expected 3c@%0d", q_data[0], q_start[0], e0 + 1); end
    end
  endtask

  task automatic test_default_rate();
    int unsigned e0, s, n, fc;
    wr_en2 = 1'b1; wr_data2 = 8'h55;
    @(negedge clk);
    wr_en2 = 1'b0; e0 = cyc;
    @(negedge clk);
    s = cyc;
    n_checks++; if (tx2 !== 1'b0) begin n_fail++; $display("FAIL dflt_start: got %b expected 0", tx2); end
    n = 1;
    while (n < 3000) begin @(negedge clk); if (tx2 !== 1'b0) break; n++; end
    n_checks++; if (n != 1250) begin n_fail++; $display("FAIL dflt_start_width: got %0d expected 1250", n); end
    n = 1;
    while (n < 3000) begin @(negedge clk); if (tx2 !== 1'b1) break; n++; end
    n_checks++; if (n != 1250) begin n_fail++; $display("FAIL dflt_bit0_width: got %0d expected 1250", n); end
    n = 1;
    while (n < 3000) begin @(negedge clk); if (tx2 !== 1'b0) break; n++; end
    n_checks++; if (n != 1250) begin n_fail++; $display("FAIL dflt_bit1_width: got %0d expected 1250", n); end
    fc = 0;
    for (int k = 0; k < 13000; k++) begin
      @(negedge clk);
      if (!busy2) begin fc = cyc; break; end
    end
    n_checks++; if (fc != s + 12500) begin n_fail++; $display("FAIL dflt_frame_len: got %0d expected %0d", fc - s, 12500); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simul_pop_write();
    test_reset_mid_frame();
    test_default_rate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
